// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared FSM encoding, digit indices and BCD helpers for the score display
package pong_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [1:0] P1_UNITS = 2'd0;
  localparam logic [1:0] P1_TENS  = 2'd1;
  localparam logic [1:0] P2_UNITS = 2'd2;
  localparam logic [1:0] P2_TENS  = 2'd3;

  // Packs a decimal value 0..99 as {tens, units}.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned v);
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] u;
    t = BCD_W'(v / 10);
    u = BCD_W'(v % 10);
    return {t, u};
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// rtl/bcd_counter2.sv - two-digit BCD counter, saturating at 99, with clear
import pong_pkg::*;

module bcd_counter2 (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_units,
  output logic             o_at_max
);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_units;

  assign o_tens   = r_tens;
  assign o_units  = r_units;
  assign o_at_max = (r_tens == BCD_W'(9)) && (r_units == BCD_W'(9));

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_inc && !o_at_max) begin
      if (r_units == BCD_W'(9)) begin
        r_units <= '0;
        r_tens  <= r_tens + BCD_W'(1);
      end else begin
        r_units <= r_units + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - two-player BCD scoreboard that refreshes four digit decoders by scan
import pong_pkg::*;

module score_display_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p1_point,
  input  logic             p2_point,
  input  logic             clear_scores,
  output logic [BCD_W-1:0] digit_val,
  output logic [1:0]       digit_sel,
  output logic             digit_update,
  output logic             busy,
  output logic             game_over,
  output logic             winner
);

  localparam logic [2*BCD_W-1:0] WIN_BCD   = to_bcd2(WIN_SCORE);
  localparam logic [3:0]         HOLD_LAST = 4'(HOLD_CYCLES - 1);

  logic [BCD_W-1:0] w_p1_tens, w_p1_units, w_p2_tens, w_p2_units;
  logic             w_p1_max, w_p2_max, w_p1_win, w_p2_win;
  logic             w_p1_inc, w_p2_inc, w_change, w_consume;
  logic [BCD_W-1:0] w_mux;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [BCD_W-1:0] r_val, w_val_nxt;
  logic [3:0]       r_hold, w_hold_nxt;
  logic             r_pending;

  // Scores freeze at WIN_SCORE, so the end-of-game flags follow the registered scores directly.
  assign w_p1_win  = ({w_p1_tens, w_p1_units} == WIN_BCD);
  assign w_p2_win  = ({w_p2_tens, w_p2_units} == WIN_BCD);
  assign game_over = w_p1_win | w_p2_win;
  assign winner    = w_p2_win & ~w_p1_win;

  assign w_p1_inc = p1_point & ~game_over & ~clear_scores;
  assign w_p2_inc = p2_point & ~game_over & ~clear_scores;
  assign w_change = clear_scores | (w_p1_inc & ~w_p1_max) | (w_p2_inc & ~w_p2_max);

  bcd_counter2 u_p1 (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_p1_inc),
    .i_clr    (clear_scores),
    .o_tens   (w_p1_tens),
    .o_units  (w_p1_units),
    .o_at_max (w_p1_max)
  );

  bcd_counter2 u_p2 (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_p2_inc),
    .i_clr    (clear_scores),
    .o_tens   (w_p2_tens),
    .o_units  (w_p2_units),
    .o_at_max (w_p2_max)
  );

  always_comb begin
    case (r_sel)
      P1_UNITS: w_mux = w_p1_units;
      P1_TENS:  w_mux = w_p1_tens;
      P2_UNITS: w_mux = w_p2_units;
      default:  w_mux = w_p2_tens;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_val_nxt    = r_val;
    w_hold_nxt   = r_hold;
    w_consume    = 1'b0;
    busy         = 1'b1;
    digit_update = 1'b0;
    digit_val    = r_val;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (r_pending) begin
          w_consume   = 1'b1;
          w_sel_nxt   = P1_UNITS;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        // Live score sampled here, then held through STROBE and HOLD.
        digit_val   = w_mux;
        w_val_nxt   = w_mux;
        w_state_nxt = STROBE;
      end
      STROBE: begin
        digit_update = 1'b1;
        w_hold_nxt   = '0;
        w_state_nxt  = HOLD;
      end
      HOLD: begin
        if (r_hold == HOLD_LAST) begin
          if (r_sel == P2_TENS) begin
            w_state_nxt = IDLE;
          end else begin
            w_sel_nxt   = r_sel + 2'd1;
            w_state_nxt = SETUP;
          end
        end else begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign digit_sel = r_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sel     <= P1_UNITS;
      r_val     <= '0;
      r_hold    <= '0;
      r_pending <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_val     <= w_val_nxt;
      r_hold    <= w_hold_nxt;
      // A change seen while a scan is being launched still forces one more scan.
      r_pending <= w_change | (r_pending & ~w_consume);
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - randomized self-checking bench with integer score model and decoder capture
module tb_score_display_ctrl;

  localparam int WIN0 = 11;
  localparam int WIN1 = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       clear_scores = 1'b0;
  logic [3:0] dv[2];
  logic [1:0] ds[2];
  logic       du[2];
  logic       bz[2];
  logic       go[2];
  logic       wn[2];

  int checks = 0;
  int errors = 0;

  int         m1[2];
  int         m2[2];
  logic       rst_q = 1'b0;
  int         snap1[2];
  int         snap2[2];
  int         exp_sel[2];
  logic       prev_du[2];
  logic [3:0] disp[2][4];
  int         strobes[2];

  always #5 clk = ~clk;

  score_display_ctrl #(.WIN_SCORE(WIN0), .HOLD_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .p1_point(p1_point), .p2_point(p2_point),
    .clear_scores(clear_scores), .digit_val(dv[0]), .digit_sel(ds[0]),
    .digit_update(du[0]), .busy(bz[0]), .game_over(go[0]), .winner(wn[0])
  );

  score_display_ctrl #(.WIN_SCORE(WIN1), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .p1_point(p1_point), .p2_point(p2_point),
    .clear_scores(clear_scores), .digit_val(dv[1]), .digit_sel(ds[1]),
    .digit_update(du[1]), .busy(bz[1]), .game_over(go[1]), .winner(wn[1])
  );

  function automatic int wv(input int k);
    return (k == 0) ? WIN0 : WIN1;
  endfunction

  function automatic logic [3:0] digit_of(input int a, input int b, input int s);
    case (s)
      0:       return 4'(a % 10);
      1:       return 4'(a / 10);
      2:       return 4'(b % 10);
      default: return 4'(b / 10);
    endcase
  endfunction

  // Game rules as plain integers: scores stop changing once someone holds the winning score.
  always @(posedge clk) begin
    rst_q <= reset;
    for (int k = 0; k < 2; k++) begin
      if (reset || clear_scores) begin
        m1[k] <= 0;
        m2[k] <= 0;
      end else if (!(m1[k] == wv(k) || m2[k] == wv(k))) begin
        if (p1_point) m1[k] <= (m1[k] >= 99) ? 99 : m1[k] + 1;
        if (p2_point) m2[k] <= (m2[k] >= 99) ? 99 : m2[k] + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic       e_go;
      logic       e_wn;
      logic [3:0] e_val;
      if (rst_q) exp_sel[k] = 0;
      e_go = (m1[k] == wv(k)) || (m2[k] == wv(k));
      e_wn = e_go && (m1[k] != wv(k));
      checks++;
      if (go[k] !== e_go || wn[k] !== e_wn) begin
        errors++;
        $display("FAIL flags dut%0d: game_over=%b winner=%b, expected %b %b", k, go[k], wn[k], e_go, e_wn);
      end
      if (du[k] === 1'b1) begin
        checks++;
        if (prev_du[k] === 1'b1) begin
          errors++;
          $display("FAIL strobe_width dut%0d: digit_update high two cycles running", k);
        end
        e_val = digit_of(snap1[k], snap2[k], exp_sel[k]);
        checks++;
        if (ds[k] !== 2'(exp_sel[k]) || dv[k] !== e_val) begin
          errors++;
          $display("FAIL strobe dut%0d: sel=%0d val=%0d, expected sel=%0d val=%0d", k, ds[k], dv[k], exp_sel[k], e_val);
        end
        disp[k][ds[k]] = dv[k];
        strobes[k]++;
        exp_sel[k] = (exp_sel[k] + 1) % 4;
      end
      prev_du[k] = du[k];
      snap1[k] = m1[k];
      snap2[k] = m2[k];
    end
  endtask

  task automatic pulse(input logic a, input logic b, input logic c);
    p1_point = a;
    p2_point = b;
    clear_scores = c;
    tick();
    p1_point = 1'b0;
    p2_point = 1'b0;
    clear_scores = 1'b0;
  endtask

  task automatic wait_quiet();
    int run = 0;
    for (int i = 0; i < 300 && run < 3; i++) begin
      tick();
      if (!bz[0] && !bz[1]) run++;
      else run = 0;
    end
    checks++;
    if (run < 3) begin
      errors++;
      $display("FAIL wait_quiet: busy still toggling after 300 cycles, expected idle");
    end
  endtask

  task automatic test_reset();
    int busy_cnt = 0;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (ds[0] !== 2'd0 || dv[0] !== 4'd0 || du[0] !== 1'b0 || bz[0] !== 1'b0 || go[0] !== 1'b0 || wn[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: sel=%0d val=%0d upd=%b busy=%b go=%b win=%b, expected all zero",
               ds[0], dv[0], du[0], bz[0], go[0], wn[0]);
    end
    for (int k = 0; k < 2; k++) begin
      strobes[k] = 0;
      for (int s = 0; s < 4; s++) disp[k][s] = 4'hF;
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bz[0]) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 12) begin
      errors++;
      $display("FAIL reset_scan_len: busy for %0d cycles, expected 12", busy_cnt);
    end
    checks++;
    if (strobes[0] != 4 || strobes[1] != 4) begin
      errors++;
      $display("FAIL reset_scan_strobes: %0d/%0d strobes, expected 4/4", strobes[0], strobes[1]);
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (disp[0][s] !== 4'd0) begin
        errors++;
        $display("FAIL reset_scan_digit%0d: got %0d, expected 0", s, disp[0][s]);
      end
    end
  endtask

  task automatic test_rollover();
    pulse(1'b0, 1'b0, 1'b1);
    wait_quiet();
    for (int i = 0; i < 9; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_quiet();
    checks++;
    if (disp[0][0] !== 4'd9 || disp[0][1] !== 4'd0) begin
      errors++;
      $display("FAIL rollover_9: P1 shows %0d%0d, expected 09", disp[0][1], disp[0][0]);
    end
    pulse(1'b1, 1'b0, 1'b0);
    wait_quiet();
    checks++;
    if (disp[0][0] !== 4'd0 || disp[0][1] !== 4'd1 || disp[0][2] !== 4'd0 || disp[0][3] !== 4'd0) begin
      errors++;
      $display("FAIL rollover_10: digits %0d %0d %0d %0d, expected 0 1 0 0",
               disp[0][0], disp[0][1], disp[0][2], disp[0][3]);
    end
  endtask

  task automatic test_simultaneous();
    int s0;
    pulse(1'b0, 1'b0, 1'b1);
    wait_quiet();
    s0 = strobes[0];
    pulse(1'b1, 1'b1, 1'b0);
    wait_quiet();
    checks++;
    if (strobes[0] - s0 != 4) begin
      errors++;
      $display("FAIL simul_scans: %0d strobes, expected 4", strobes[0] - s0);
    end
    checks++;
    if (disp[0][0] !== 4'd1 || disp[0][1] !== 4'd0 || disp[0][2] !== 4'd1 || disp[0][3] !== 4'd0) begin
      errors++;
      $display("FAIL simul_digits: %0d %0d %0d %0d, expected 1 0 1 0",
               disp[0][0], disp[0][1], disp[0][2], disp[0][3]);
    end
  endtask

  task automatic test_game_over();
    pulse(1'b0, 1'b0, 1'b1);
    wait_quiet();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (go[1] !== 1'b1 || wn[1] !== 1'b1) begin
      errors++;
      $display("FAIL p2_wins: go=%b win=%b, expected 1 1", go[1], wn[1]);
    end
    pulse(1'b1, 1'b0, 1'b0);
    wait_quiet();
    checks++;
    if (disp[1][0] !== 4'd0 || disp[1][1] !== 4'd0 || disp[1][2] !== 4'd3) begin
      errors++;
      $display("FAIL ignore_after_win: P1=%0d%0d P2u=%0d, expected 00 3", disp[1][1], disp[1][0], disp[1][2]);
    end
    pulse(1'b1, 1'b1, 1'b1);
    wait_quiet();
    checks++;
    if (go[1] !== 1'b0 || disp[1][0] !== 4'd0 || disp[1][2] !== 4'd0 || disp[0][0] !== 4'd0 || disp[0][2] !== 4'd0) begin
      errors++;
      $display("FAIL clear_priority: go1=%b d1=%0d,%0d d0=%0d,%0d, expected 0 and zeros",
               go[1], disp[1][0], disp[1][2], disp[0][0], disp[0][2]);
    end
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (go[1] !== 1'b1 || wn[1] !== 1'b0) begin
      errors++;
      $display("FAIL tie_winner: go=%b win=%b, expected 1 0", go[1], wn[1]);
    end
    wait_quiet();
  endtask

  task automatic test_midscan();
    int cnt = 0;
    int s0;
    pulse(1'b0, 1'b0, 1'b1);
    wait_quiet();
    s0 = strobes[0];
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !bz[0]; i++) tick();
    if (bz[0]) cnt = 1;
    while (cnt > 0 && cnt < 40) begin
      p2_point = (cnt == 5);
      tick();
      p2_point = 1'b0;
      if (bz[0]) cnt++;
      else break;
    end
    checks++;
    if (cnt != 12) begin
      errors++;
      $display("FAIL midscan_len: first scan busy %0d cycles, expected 12", cnt);
    end
    tick();
    checks++;
    if (bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL midscan_restart: busy=%b one cycle after idle, expected 1", bz[0]);
    end
    wait_quiet();
    checks++;
    if (strobes[0] - s0 != 8 || disp[0][0] !== 4'd1 || disp[0][2] !== 4'd1) begin
      errors++;
      $display("FAIL midscan_result: strobes=%0d P1u=%0d P2u=%0d, expected 8 1 1",
               strobes[0] - s0, disp[0][0], disp[0][2]);
    end
  endtask

  task automatic test_reset_midscan();
    int  s0;
    logic found = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (du[0] === 1'b1 && ds[0] === 2'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_midscan_wait: no strobe of digit 2 within 40 cycles");
    end
    reset = 1'b1;
    tick();
    checks++;
    if (du[0] !== 1'b0 || ds[0] !== 2'd0 || dv[0] !== 4'd0 || bz[0] !== 1'b0 || go[0] !== 1'b0 || wn[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_midscan_values: upd=%b sel=%0d val=%0d busy=%b go=%b win=%b, expected zeros",
               du[0], ds[0], dv[0], bz[0], go[0], wn[0]);
    end
    for (int s = 0; s < 4; s++) disp[0][s] = 4'hF;
    s0 = strobes[0];
    reset = 1'b0;
    wait_quiet();
    checks++;
    if (strobes[0] - s0 != 4 || disp[0][0] !== 4'd0 || disp[0][1] !== 4'd0 || disp[0][2] !== 4'd0 || disp[0][3] !== 4'd0) begin
      errors++;
      $display("FAIL reset_midscan_rescan: %0d strobes digits %0d %0d %0d %0d, expected 4 strobes of 0",
               strobes[0] - s0, disp[0][0], disp[0][1], disp[0][2], disp[0][3]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      p1_point = ($urandom_range(0, 99) < 20);
      p2_point = ($urandom_range(0, 99) < 20);
      clear_scores = ($urandom_range(0, 99) < 3);
      tick();
    end
    p1_point = 1'b0;
    p2_point = 1'b0;
    clear_scores = 1'b0;
    wait_quiet();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (disp[k][s] !== digit_of(m1[k], m2[k], s)) begin
          errors++;
          $display("FAIL random_display dut%0d digit%0d: got %0d, expected %0d",
                   k, s, disp[k][s], digit_of(m1[k], m2[k], s));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      exp_sel[k] = 0;
      prev_du[k] = 1'b0;
      snap1[k] = 0;
      snap2[k] = 0;
      strobes[k] = 0;
      for (int s = 0; s < 4; s++) disp[k][s] = 4'hF;
    end
    test_reset();
    test_rollover();
    test_simultaneous();
    test_game_over();
    test_midscan();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
